uartreader: RTL and testbench

UART receive front end, the mirror of the transmit path. It oversamples the asynchronous `rx` line and deserialises 8N1 frames. Each valid byte is pushed into the RX FIFO through a single-cycle write strobe, and the core drains that FIFO. Framing errors and FIFO overruns are reported to the status logic.

---
 rtl/uartreader_pkg.sv | 23 ++
 rtl/uartreader_rx.sv | 135 +++++++++++++
 rtl/uartreader.sv | 76 +++++++
 tb/tb_uartreader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uartreader_pkg.sv
// rtl/uartreader_pkg.sv - shared UART receive types and constants
//
// Purpose: state encoding and framing constants shared by uart_rx and
//          uartreader.
// Contents:
//   uart_state_t          receive FSM states
//   DEFAULT_CLKS_PER_BIT  clocks per bit at 66.67 MHz / 115200 baud
//   UART_FRAME_BITS       start + 8 data + stop
package uartreader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PUSH,
        WAIT_IDLE
    } uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 579;
    localparam int UART_FRAME_BITS      = 10;

endpackage

// File: rtl/uartreader_rx.sv
// rtl/uartreader_rx.sv - 8N1 deserialiser: synchroniser, baud counter, shift register
//
// Purpose: oversamples the asynchronous rx line and recovers one byte per frame.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   rx_i         asynchronous serial input, idle high
//   state_o      current receive state
//   byte_o       assembled byte, stable while valid_o=1
//   valid_o      high for the single PUSH cycle of a good frame
//   ferr_o       one-cycle pulse after a stop bit sampled low
//   receiving_o  high from confirmed start bit until PUSH completes
module uart_rx
    import uartreader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output uart_state_t          state_o,
    output logic [DATA_BITS-1:0] byte_o,
    output logic                 valid_o,
    output logic                 ferr_o,
    output logic                 receiving_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    uart_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 recv_q, recv_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            recv_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            recv_q    <= recv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        recv_d  = recv_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                // Half-bit wait lands every later sample at mid-bit.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                        recv_d  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) state_d = STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets a zero-gap next start bit be caught.
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = PUSH;
                    end else begin
                        state_d = WAIT_IDLE;
                        ferr_d  = 1'b1;
                        recv_d  = 1'b0;
                    end
                end
            end
            PUSH: begin
                cnt_d   = '0;
                state_d = IDLE;
                recv_d  = 1'b0;
            end
            WAIT_IDLE: begin
                // A stuck-low line must not be mistaken for a new start bit.
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign state_o     = state_q;
    assign byte_o      = shift_q;
    assign valid_o     = (state_q == PUSH);
    assign ferr_o      = ferr_q;
    assign receiving_o = recv_q;

endmodule

// File: rtl/uartreader.sv
// rtl/uartreader.sv - UART receive front end feeding the RX FIFO
//
// Purpose: wraps uart_rx with the single-cycle FIFO push / overrun handshake.
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   rx             asynchronous serial input, idle high
//   fifo_full      RX FIFO cannot accept a write this cycle
//   fifo_data      received byte, zero-extended; valid while fifo_write_en=1
//   fifo_write_en  one-cycle write strobe to the RX FIFO
//   receiving      high from confirmed start bit until return to IDLE
//   frame_error    one-cycle pulse when the stop bit samples 0
//   overrun        one-cycle pulse when a valid byte is dropped (fifo_full=1)
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uartreader
    import uartreader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic                   fifo_full,
    output logic [`DATA_WIDTH-1:0] fifo_data,
    output logic                   fifo_write_en,
    output logic                   receiving,
    output logic                   frame_error,
    output logic                   overrun
);

    uart_state_t            rx_state;
    logic [DATA_BITS-1:0]   rx_byte;
    logic                   rx_valid;
    logic                   rx_ferr;
    logic                   rx_receiving;
    logic                   push_ok;
    logic [`DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS)
    ) u_rx (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .state_o     (rx_state),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .ferr_o      (rx_ferr),
        .receiving_o (rx_receiving)
    );

    // Outputs are qualified with rst so a reset cycle never shows a strobe.
    assign push_ok = rx_valid & ~fifo_full & ~rst;

    always_comb begin
        fifo_data_d = fifo_data_q;
        if (push_ok) fifo_data_d = `DATA_WIDTH'(rx_byte);
    end

    always_ff @(posedge clk) begin
        if (rst) fifo_data_q <= '0;
        else     fifo_data_q <= fifo_data_d;
    end

    assign fifo_data     = rst ? '0 : fifo_data_d;
    assign fifo_write_en = push_ok;
    assign overrun       = rx_valid & fifo_full & ~rst;
    assign frame_error   = rx_ferr & ~rst;
    assign receiving     = rx_receiving & ~rst;

endmodule

// File: tb/tb_uartreader.sv
// tb/tb_uartreader.sv - self-checking bench for uartreader
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_uartreader;
    import uartreader_pkg::*;

    localparam int CPB    = 16;
    localparam int MAXC   = 4096;
    // rx driven at cycle n: 2 sync cycles + 1 IDLE cycle, then half a bit of START.
    localparam int T_RISE = 3 + CPB / 2;
    // mid-stop sample is 9 full bits after start confirm; strobe is the cycle after.
    localparam int T_EV   = T_RISE + 9 * CPB;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   rx = 1'b1;
    logic                   fifo_full = 1'b0;
    logic [`DATA_WIDTH-1:0] fifo_data;
    logic                   fifo_write_en, receiving, frame_error, overrun;

    always #5 clk = ~clk;

    uartreader #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) reader (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .fifo_full     (fifo_full),
        .fifo_data     (fifo_data),
        .fifo_write_en (fifo_write_en),
        .receiving     (receiving),
        .frame_error   (frame_error),
        .overrun       (overrun)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    bit         exp_we  [MAXC];
    bit         exp_fe  [MAXC];
    bit         exp_ov  [MAXC];
    bit         exp_rcv [MAXC];
    logic [7:0] exp_dat [MAXC];
    logic [7:0] hold = 8'h00;
    logic [7:0] got[$];
    int         n_fe = 0;
    int         n_ov = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            if (rst) hold = 8'h00;
            check("fifo_write_en", int'(fifo_write_en), int'(exp_we[cyc]));
            check("frame_error",   int'(frame_error),   int'(exp_fe[cyc]));
            check("overrun",       int'(overrun),       int'(exp_ov[cyc]));
            check("receiving",     int'(receiving),     int'(exp_rcv[cyc]));
            if (exp_we[cyc]) begin
                check("fifo_data", int'(fifo_data), int'(exp_dat[cyc]));
                hold = exp_dat[cyc];
            end else begin
                check("fifo_data_hold", int'(fifo_data), int'(hold));
            end
            if (fifo_write_en) got.push_back(fifo_data[7:0]);
            if (frame_error) n_fe++;
            if (overrun) n_ov++;
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Caller must be aligned to 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int stop_bits, input logic full);
        int n;
        n = cyc;
        fifo_full = full;
        if (n + T_EV + 1 < MAXC) begin
            for (int i = n + T_RISE; i <= n + T_EV - (stop_val ? 0 : 1); i++)
                exp_rcv[i] = 1'b1;
            if (!stop_val)  exp_fe[n + T_EV] = 1'b1;
            else if (full)  exp_ov[n + T_EV] = 1'b1;
            else begin
                exp_we[n + T_EV]  = 1'b1;
                exp_dat[n + T_EV] = b;
            end
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        for (int i = 0; i < stop_bits; i++) drive_bit(stop_val);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] lit [6];

    initial begin
        int n;
        lit = '{8'hAA, 8'h12, 8'h34, 8'hFF, 8'h81, 8'h3C};

        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", int'(reader.rx_state), int'(IDLE));
        check("reset_fifo_data", int'(fifo_data), 0);

        // Idle line
        repeat (100) begin
            @(negedge clk);
            check("idle_state", int'(reader.rx_state), int'(IDLE));
        end

        // Single byte
        align();
        send_frame(8'hAA, 1'b1, 1, 1'b0);
        @(negedge clk);
        check("after_aa_state", int'(reader.rx_state), int'(IDLE));

        // Glitch shorter than half a bit
        align();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        @(negedge clk);
        check("glitch_start", int'(reader.rx_state), int'(START));
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("glitch_idle", int'(reader.rx_state), int'(IDLE));

        // Framing error, line held low for 3 bits
        align();
        send_frame(8'h55, 1'b0, 3, 1'b0);
        @(negedge clk);
        check("ferr_wait_idle", int'(reader.rx_state), int'(WAIT_IDLE));
        align();
        rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ferr_still_wait", int'(reader.rx_state), int'(WAIT_IDLE));
        @(posedge clk);
        @(negedge clk);
        check("ferr_back_idle", int'(reader.rx_state), int'(IDLE));

        // Back-to-back, zero idle gap
        align();
        send_frame(8'h12, 1'b1, 1, 1'b0);
        send_frame(8'h34, 1'b1, 1, 1'b0);
        send_frame(8'hFF, 1'b1, 1, 1'b0);

        // Overrun then recovery
        align();
        send_frame(8'h7E, 1'b1, 1, 1'b1);
        fifo_full = 1'b0;
        @(negedge clk);
        check("overrun_keeps_data", int'(fifo_data), 32'hFF);
        align();
        send_frame(8'h81, 1'b1, 1, 1'b0);

        // Reset in the middle of a frame
        align();
        n = cyc;
        for (int i = n + T_RISE; i < n + 40; i++) exp_rcv[i] = 1'b1;
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_state", int'(reader.rx_state), int'(IDLE));
        check("midreset_data", int'(fifo_data), 0);
        align();
        send_frame(8'h3C, 1'b1, 1, 1'b0);

        repeat (10) @(negedge clk);

        check("write_count", got.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) check("write_value", int'(got[i]), int'(lit[i]));
        end
        check("frame_error_count", n_fe, 1);
        check("overrun_count", n_ov, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
